// File: rtl/vga_pkg.sv
// Shared VGA constants, the 3-3-2 colour type and the clamped step helpers
// used by the sprite position update.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // RRRGGGBB; the VGA controller expands each field to 4 bits
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t BLANK_COLOR  = 8'h00;
    localparam rgb_t BG_COLOR     = 8'h03;
    localparam rgb_t SPRITE_COLOR = 8'hE0;
    localparam rgb_t BORDER_COLOR = 8'hFF;

    function automatic logic [10:0] step_down(input logic [10:0] v,
                                              input logic [10:0] step);
        return (v < step) ? 11'd0 : v - step;
    endfunction

    function automatic logic [10:0] step_up(input logic [10:0] v,
                                            input logic [10:0] step,
                                            input logic [10:0] vmax);
        logic [10:0] sum;
        sum = v + step;
        return (sum > vmax) ? vmax : sum;
    endfunction

endpackage

// File: rtl/btn_sync_latch.sv
// One controller button: 2-flop synchroniser feeding a sticky press latch.
// The frame clear loses to a press seen in the same cycle.
module btn_sync_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_clear,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_latch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (i_clear)
                r_latch <= r_sync2;
            else
                r_latch <= r_latch | r_sync2;
        end
    end

    assign o_press = r_latch;

endmodule

// File: rtl/sprite_renderer.sv
// Pixel colour source for the VGA controller: border, background and one
// square sprite whose position moves once per frame from latched buttons.
module sprite_renderer
    import vga_pkg::*;
#(
    parameter int SPRITE_SIZE = 32,
    parameter int STEP        = 4
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [9:0] i_X,
    input  logic [9:0] i_Y,
    input  logic       i_ACTIVE,
    input  logic       i_FRAME_START,
    input  logic       i_BTN_UP,
    input  logic       i_BTN_DOWN,
    input  logic       i_BTN_LEFT,
    input  logic       i_BTN_RIGHT,
    output logic [7:0] o_RGB,
    output logic [9:0] o_POS_X,
    output logic [9:0] o_POS_Y
);

    localparam logic [10:0] C_MAX_X  = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0] C_MAX_Y  = 11'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0] C_STEP   = 11'(STEP);
    localparam logic [10:0] C_SIZE   = 11'(SPRITE_SIZE);
    localparam logic [9:0]  C_RST_X  = 10'((H_ACTIVE - SPRITE_SIZE) / 2);
    localparam logic [9:0]  C_RST_Y  = 10'((V_ACTIVE - SPRITE_SIZE) / 2);
    localparam logic [9:0]  C_X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  C_Y_LAST = 10'(V_ACTIVE - 1);

    logic [3:0] w_btn;
    logic [3:0] w_press;
    logic       w_up;
    logic       w_down;
    logic       w_left;
    logic       w_right;

    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [9:0] w_pos_x_next;
    logic [9:0] w_pos_y_next;

    rgb_t        r_rgb;
    rgb_t        w_rgb_next;
    logic        w_in_range;
    logic        w_border;
    logic        w_hit;
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_px11;
    logic [10:0] w_py11;

    assign w_btn = {i_BTN_UP, i_BTN_DOWN, i_BTN_LEFT, i_BTN_RIGHT};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_sync_latch u_btn (
            .i_clk   (i_CLK),
            .i_rst_n (i_RESET),
            .i_btn   (w_btn[g]),
            .i_clear (i_FRAME_START),
            .o_press (w_press[g])
        );
    end

    assign w_up    = w_press[3];
    assign w_down  = w_press[2];
    assign w_left  = w_press[1];
    assign w_right = w_press[0];

    assign w_px11 = {1'b0, r_pos_x};
    assign w_py11 = {1'b0, r_pos_y};

    // Opposing buttons in the same frame cancel on that axis
    always_comb begin
        w_pos_x_next = r_pos_x;
        w_pos_y_next = r_pos_y;
        if (w_left && !w_right)
            w_pos_x_next = 10'(step_down(w_px11, C_STEP));
        else if (w_right && !w_left)
            w_pos_x_next = 10'(step_up(w_px11, C_STEP, C_MAX_X));
        if (w_up && !w_down)
            w_pos_y_next = 10'(step_down(w_py11, C_STEP));
        else if (w_down && !w_up)
            w_pos_y_next = 10'(step_up(w_py11, C_STEP, C_MAX_Y));
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_pos_x <= C_RST_X;
            r_pos_y <= C_RST_Y;
        end else if (i_FRAME_START) begin
            r_pos_x <= w_pos_x_next;
            r_pos_y <= w_pos_y_next;
        end
    end

    assign w_x11 = {1'b0, i_X};
    assign w_y11 = {1'b0, i_Y};

    // Out-of-range coordinates fall through to background, never wrap
    assign w_in_range = (i_X <= C_X_LAST) && (i_Y <= C_Y_LAST);
    assign w_border   = w_in_range &&
                        ((i_X == 10'd0) || (i_X == C_X_LAST) ||
                         (i_Y == 10'd0) || (i_Y == C_Y_LAST));
    assign w_hit      = w_in_range &&
                        (w_x11 >= w_px11) && (w_x11 < w_px11 + C_SIZE) &&
                        (w_y11 >= w_py11) && (w_y11 < w_py11 + C_SIZE);

    always_comb begin
        w_rgb_next = BLANK_COLOR;
        if (!i_ACTIVE)
            w_rgb_next = BLANK_COLOR;
        else if (w_border)
            w_rgb_next = BORDER_COLOR;
        else if (w_hit)
            w_rgb_next = SPRITE_COLOR;
        else
            w_rgb_next = BG_COLOR;
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET)
            r_rgb <= BLANK_COLOR;
        else
            r_rgb <= w_rgb_next;
    end

    assign o_RGB   = r_rgb;
    assign o_POS_X = r_pos_x;
    assign o_POS_Y = r_pos_y;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: pixel colours, clamped movement,
// opposing-button cancel, set-over-clear latch and mid-frame reset.
module tb_sprite_renderer;

    logic       i_CLK;
    logic       i_RESET;
    logic [9:0] i_X;
    logic [9:0] i_Y;
    logic       i_ACTIVE;
    logic       i_FRAME_START;
    logic       i_BTN_UP;
    logic       i_BTN_DOWN;
    logic       i_BTN_LEFT;
    logic       i_BTN_RIGHT;
    logic [7:0] o_RGB;
    logic [9:0] o_POS_X;
    logic [9:0] o_POS_Y;

    int n_tests;
    int n_fail;
    int ex;
    int ey;

    sprite_renderer dut (
        .i_CLK         (i_CLK),
        .i_RESET       (i_RESET),
        .i_X           (i_X),
        .i_Y           (i_Y),
        .i_ACTIVE      (i_ACTIVE),
        .i_FRAME_START (i_FRAME_START),
        .i_BTN_UP      (i_BTN_UP),
        .i_BTN_DOWN    (i_BTN_DOWN),
        .i_BTN_LEFT    (i_BTN_LEFT),
        .i_BTN_RIGHT   (i_BTN_RIGHT),
        .o_RGB         (o_RGB),
        .o_POS_X       (o_POS_X),
        .o_POS_Y       (o_POS_Y)
    );

    initial i_CLK = 1'b0;
    always #20 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one pixel between edges, sample the registered colour a cycle later
    task automatic pixel(input string tag, input int x, input int y, input logic act,
                         input logic [7:0] exp);
        i_X      = 10'(x);
        i_Y      = 10'(y);
        i_ACTIVE = act;
        @(negedge i_CLK);
        chk(tag, {2'b00, o_RGB}, {2'b00, exp});
    endtask

    task automatic frame();
        i_FRAME_START = 1'b1;
        @(negedge i_CLK);
        i_FRAME_START = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        i_RESET       = 1'b0;
        i_X           = '0;
        i_Y           = '0;
        i_ACTIVE      = 1'b0;
        i_FRAME_START = 1'b0;
        i_BTN_UP      = 1'b0;
        i_BTN_DOWN    = 1'b0;
        i_BTN_LEFT    = 1'b0;
        i_BTN_RIGHT   = 1'b0;

        idle(2);
        chk("reset_rgb", {2'b00, o_RGB}, 10'h000);
        chk("reset_pos_x", o_POS_X, 10'd304);
        chk("reset_pos_y", o_POS_Y, 10'd224);
        i_RESET = 1'b1;

        pixel("px_center", 320, 240, 1'b1, 8'hE0);
        pixel("px_left_border", 0, 100, 1'b1, 8'hFF);
        pixel("px_bg", 100, 100, 1'b1, 8'h03);
        pixel("px_blank", 320, 240, 1'b0, 8'h00);
        pixel("px_edge_303", 303, 224, 1'b1, 8'h03);
        pixel("px_edge_304", 304, 224, 1'b1, 8'hE0);
        pixel("px_edge_335", 335, 255, 1'b1, 8'hE0);
        pixel("px_edge_336", 336, 255, 1'b1, 8'h03);
        pixel("px_top_border", 200, 0, 1'b1, 8'hFF);
        pixel("px_right_border", 639, 300, 1'b1, 8'hFF);
        pixel("px_out_of_range", 700, 100, 1'b1, 8'h03);
        i_ACTIVE = 1'b0;

        // LEFT held: 304 down to 0 in steps of 4, then clamped
        ex = 304;
        ey = 224;
        i_BTN_LEFT = 1'b1;
        idle(4);
        for (int k = 0; k < 100; k++) begin
            frame();
            ex = (ex < 4) ? 0 : ex - 4;
            chk("left_pos_x", o_POS_X, 10'(ex));
            chk("left_pos_y", o_POS_Y, 10'(ey));
            idle(3);
        end
        i_BTN_LEFT = 1'b0;
        idle(4);
        frame();
        chk("left_drain_x", o_POS_X, 10'd0);
        idle(3);
        frame();
        chk("idle_frame_x", o_POS_X, 10'd0);
        chk("idle_frame_y", o_POS_Y, 10'd224);

        // RIGHT+DOWN held: both axes clamp at 608 / 448
        i_BTN_RIGHT = 1'b1;
        i_BTN_DOWN  = 1'b1;
        idle(4);
        for (int k = 0; k < 200; k++) begin
            frame();
            ex = (ex + 4 > 608) ? 608 : ex + 4;
            ey = (ey + 4 > 448) ? 448 : ey + 4;
            chk("rd_pos_x", o_POS_X, 10'(ex));
            chk("rd_pos_y", o_POS_Y, 10'(ey));
            idle(3);
        end
        chk("rd_final_x", o_POS_X, 10'd608);
        chk("rd_final_y", o_POS_Y, 10'd448);
        pixel("px_corner_border", 639, 479, 1'b1, 8'hFF);
        pixel("px_sprite_max", 608, 448, 1'b1, 8'hE0);
        pixel("px_left_of_sprite", 607, 448, 1'b1, 8'h03);
        pixel("px_sprite_inner", 620, 460, 1'b1, 8'hE0);

        // Mid-frame reset with buttons still latched
        i_RESET = 1'b0;
        #1;
        chk("midreset_rgb", {2'b00, o_RGB}, 10'h000);
        chk("midreset_pos_x", o_POS_X, 10'd304);
        chk("midreset_pos_y", o_POS_Y, 10'd224);
        i_BTN_RIGHT = 1'b0;
        i_BTN_DOWN  = 1'b0;
        @(negedge i_CLK);
        i_RESET = 1'b1;
        i_ACTIVE = 1'b0;
        idle(3);
        frame();
        chk("post_reset_x", o_POS_X, 10'd304);
        chk("post_reset_y", o_POS_Y, 10'd224);

        // LEFT+RIGHT cancel; a short UP pulse still counts
        i_BTN_LEFT  = 1'b1;
        i_BTN_RIGHT = 1'b1;
        idle(4);
        i_BTN_UP = 1'b1;
        idle(3);
        i_BTN_UP = 1'b0;
        idle(4);
        frame();
        chk("lr_cancel_x", o_POS_X, 10'd304);
        chk("up_pulse_y", o_POS_Y, 10'd220);

        // UP released so its synchronised level is last high in the frame-start cycle
        idle(2);
        i_BTN_UP = 1'b1;
        idle(4);
        i_BTN_UP = 1'b0;
        @(negedge i_CLK);
        frame();
        chk("up_held_y", o_POS_Y, 10'd216);
        idle(4);
        frame();
        chk("up_relatch_y", o_POS_Y, 10'd212);
        chk("up_relatch_x", o_POS_X, 10'd304);
        idle(4);
        frame();
        chk("up_cleared_y", o_POS_Y, 10'd212);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
